// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer and the MAC core it feeds.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Accumulated result width: full product width plus one guard bit.
   function automatic int W_RES(input int szin);
      return 2 * (szin + 1) + 1;
   endfunction

endpackage

// File: rtl/fir_tap_store.sv
// Coefficient register file and sample delay line, each read through one tap selected by sel.
module fir_tap_store #(
   parameter  int SZin = 7,
   parameter  int SZN  = 5,
   localparam int KW   = $clog2(SZN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          coef_we,
   input  logic [KW-1:0] coef_addr,
   input  logic [SZin:0] coef_data,
   input  logic          shift_en,
   input  logic [SZin:0] shift_data,
   input  logic [KW-1:0] sel,
   output logic [SZin:0] rd_coef,
   output logic [SZin:0] rd_smp
);

   logic [SZin:0] c [SZN];
   logic [SZin:0] x [SZN];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: both arrays must clear on reset, so they are built from flops, not a RAM macro.
         for (int i = 0; i < SZN; i++) begin
            c[i] <= '0;
            x[i] <= '0;
         end
      end else begin
         if (coef_we && (32'(coef_addr) < SZN)) c[coef_addr] <= coef_data;
         if (shift_en) begin
            x[0] <= shift_data;
            for (int i = 1; i < SZN; i++) x[i] <= x[i-1];
         end
      end
   end

   assign rd_coef = c[sel];
   assign rd_smp  = x[sel];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences one (coefficient, sample) pair per cycle into the MAC for each accepted sample
// and captures the accumulated result as one filter output.
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter  int SZin    = 7,
   parameter  int SZN     = 5,
   parameter  int MAC_LAT = 1,
   localparam int KW      = $clog2(SZN),
   localparam int WR      = W_RES(SZin)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          coef_we,
   input  logic [KW-1:0] coef_addr,
   input  logic [SZin:0] coef_data,
   input  logic          smp_valid,
   input  logic [SZin:0] smp_data,
   output logic          smp_ready,
   output logic [SZin:0] ai,
   output logic [SZin:0] xni,
   output logic          mac_en,
   output logic          acc_clr,
   input  logic [WR-1:0] mac_res,
   output logic          out_valid,
   output logic [WR-1:0] out_data
);

   localparam int            DW     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(SZN - 1);
   localparam logic [DW-1:0] D_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

   state_t        state, state_next;
   logic [KW-1:0] k;
   logic [KW-1:0] sel;
   logic [DW-1:0] d;
   logic          accept;
   logic [SZin:0] rd_coef;
   logic [SZin:0] rd_smp;

   assign accept = (state == IDLE) && smp_valid;

   fir_tap_store #(
      .SZin (SZin),
      .SZN  (SZN)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .shift_en   (accept),
      .shift_data (smp_data),
      .sel        (sel),
      .rd_coef    (rd_coef),
      .rd_smp     (rd_smp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      smp_ready  = 1'b0;
      mac_en     = 1'b0;
      acc_clr    = 1'b0;
      out_valid  = 1'b0;
      sel        = '0;
      unique case (state)
         IDLE: begin
            smp_ready = 1'b1;
            if (smp_valid) state_next = RUN;
         end
         RUN: begin
            mac_en  = 1'b1;
            acc_clr = (k == '0);
            if (k == K_LAST) state_next = (MAC_LAT == 0) ? DONE : DRAIN;
            else             sel        = k + 1'b1;
         end
         DRAIN: begin
            if (d == D_LAST) state_next = DONE;
         end
         DONE: begin
            out_valid  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ai/xni are loaded one edge ahead of the cycle that presents them; sel already points at the next tap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k        <= '0;
         d        <= '0;
         ai       <= '0;
         xni      <= '0;
         out_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (smp_valid) begin
                  k   <= '0;
                  // A coefficient written on the accepting edge must already reach tap 0.
                  ai  <= (coef_we && (coef_addr == '0)) ? coef_data : rd_coef;
                  xni <= smp_data;
               end
            end
            RUN: begin
               d <= '0;
               if (k != K_LAST) begin
                  k   <= sel;
                  ai  <= rd_coef;
                  xni <= rd_smp;
               end
            end
            DRAIN:   d <= d + 1'b1;
            default: ;
         endcase
         // Raw copy of the MAC sum; wide sums wrap at WR bits by design.
         if (state_next == DONE) out_data <= mac_res;
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomised and directed bench for fir_tap_sequencer with a registered-accumulator MAC
// and a queue-based scoreboard fed from an arithmetic reference model.
module tb_fir_tap_sequencer;
   import fir_pkg::*;

   localparam int SZin    = 3;
   localparam int SZN     = 5;
   localparam int MAC_LAT = 1;
   localparam int KW      = $clog2(SZN);
   localparam int W       = W_RES(SZin);
   localparam int D       = SZin + 1;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          coef_we   = 1'b0;
   logic [KW-1:0] coef_addr = '0;
   logic [D-1:0]  coef_data = '0;
   logic          smp_valid = 1'b0;
   logic [D-1:0]  smp_data  = '0;
   logic          smp_ready;
   logic [D-1:0]  ai;
   logic [D-1:0]  xni;
   logic          mac_en;
   logic          acc_clr;
   logic [W-1:0]  mac_res;
   logic          out_valid;
   logic [W-1:0]  out_data;

   fir_tap_sequencer #(
      .SZin    (SZin),
      .SZN     (SZN),
      .MAC_LAT (MAC_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .smp_ready (smp_ready),
      .ai        (ai),
      .xni       (xni),
      .mac_en    (mac_en),
      .acc_clr   (acc_clr),
      .mac_res   (mac_res),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // External MAC: one registered accumulate per mac_en, result visible the next cycle.
   logic [W-1:0] acc;
   always @(posedge clk or negedge rst) begin
      if (!rst)        acc <= '0;
      else if (mac_en) acc <= (acc_clr ? '0 : acc) + (W'(ai) * W'(xni));
   end
   assign mac_res = acc;

   typedef struct {
      logic [D-1:0] a;
      logic [D-1:0] x;
      logic         clr;
   } pair_t;

   typedef struct {
      logic [W-1:0] data;
      int           cyc;
   } exp_t;

   pair_t        pair_q[$];
   exp_t         exp_q[$];
   logic [W-1:0] got_q[$];
   int           m_c [SZN];
   int           m_x [SZN];
   int           tab [SZN];
   int           tests    = 0;
   int           failed   = 0;
   int           cyc      = 0;
   int           ov_count = 0;
   pair_t        mp;
   exp_t         me;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      failed++;
      $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
   endtask

   // Reference: shift the history, then the output is sum(c[i]*x[i]) modulo 2^W.
   task automatic model_accept(input logic [D-1:0] s, input int acc_cyc);
      pair_t p;
      exp_t  e;
      int    sum;
      for (int i = SZN - 1; i > 0; i--) m_x[i] = m_x[i-1];
      m_x[0] = int'(s);
      sum = 0;
      for (int j = 0; j < SZN; j++) begin
         p.a   = D'(m_c[j]);
         p.x   = D'(m_x[j]);
         p.clr = (j == 0);
         pair_q.push_back(p);
         sum += m_c[j] * m_x[j];
      end
      e.data = W'(sum % (1 << W));
      e.cyc  = acc_cyc + SZN + MAC_LAT + 1;
      exp_q.push_back(e);
   endtask

   // Monitor: every MAC pair and every output pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (mac_en) begin
            if (pair_q.size() == 0) check("mac_en_unexpected", 32'(mac_en), 0);
            else begin
               mp = pair_q.pop_front();
               check("ai", 32'(ai), 32'(mp.a));
               check("xni", 32'(xni), 32'(mp.x));
               check("acc_clr", 32'(acc_clr), 32'(mp.clr));
            end
         end
         if (out_valid) begin
            ov_count++;
            if (exp_q.size() == 0) check("out_valid_unexpected", 32'(out_valid), 0);
            else begin
               me = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(me.data));
               check("out_valid_cycle", cyc, me.cyc);
               got_q.push_back(out_data);
            end
         end
      end
   end

   task automatic send_sample(input logic [D-1:0] s, input bit hold, input bit we,
                              input logic [KW-1:0] wa, input logic [D-1:0] wd, output int acc_cyc);
      bit rdy;
      bit done;
      int n;
      smp_valid = 1'b1;
      smp_data  = s;
      coef_we   = we;
      coef_addr = wa;
      coef_data = wd;
      done      = 1'b0;
      n         = 0;
      acc_cyc   = -1;
      while (!done && n < 64) begin
         @(negedge clk);
         rdy = smp_ready;
         @(posedge clk);
         n++;
         if (rdy) begin
            done    = 1'b1;
            acc_cyc = cyc;
            if (we && (int'(wa) < SZN)) m_c[wa] = int'(wd);
            model_accept(s, acc_cyc);
         end
      end
      if (!done) timeout("handshake");
      #1;
      if (!hold) smp_valid = 1'b0;
      coef_we = 1'b0;
   endtask

   task automatic write_coef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = KW'(a);
      coef_data = D'(v);
      @(posedge clk);
      if (a < SZN) m_c[a] = v;
      #1;
      coef_we = 1'b0;
   endtask

   task automatic flush_model();
      pair_q.delete();
      exp_q.delete();
      for (int i = 0; i < SZN; i++) begin
         m_c[i] = 0;
         m_x[i] = 0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush_model();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string name);
      check({name, "_count"}, got_q.size(), SZN);
      for (int i = 0; i < SZN && i < got_q.size(); i++) check(name, 32'(got_q[i]), tab[i]);
      got_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a_cyc [SZN];
      int tmp;
      int ov_before;
      int g;
      bit we;

      flush_model();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("reset_smp_ready", 32'(smp_ready), 1);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_mac_en", 32'(mac_en), 0);
      check("reset_out_data", 32'(out_data), 0);
      @(posedge clk);
      #1;

      // Impulse with smp_valid held high: fixed accept spacing and the coefficients read out.
      for (int i = 0; i < SZN; i++) write_coef(i, i + 1);
      got_q.delete();
      for (int i = 0; i < SZN; i++) send_sample(D'(i == 0), (i < SZN - 1), 1'b0, '0, '0, a_cyc[i]);
      wait_idle();
      for (int i = 1; i < SZN; i++) check("accept_interval", a_cyc[i] - a_cyc[i-1], SZN + MAC_LAT + 2);
      tab = '{1, 2, 3, 4, 5};
      check_outputs("impulse");

      do_reset();
      for (int i = 0; i < SZN; i++) write_coef(i, i + 1);
      for (int i = 0; i < SZN; i++) send_sample(D'(2), 1'b0, 1'b0, '0, '0, tmp);
      wait_idle();
      tab = '{2, 6, 12, 20, 30};
      check_outputs("constant2");

      // Write c[2]=7 while tap 2 of the third sample is on the bus; out-of-range writes are dropped.
      do_reset();
      for (int i = 0; i < SZN; i++) write_coef(i, i + 1);
      send_sample(D'(1), 1'b0, 1'b0, '0, '0, tmp);
      send_sample(D'(1), 1'b0, 1'b0, '0, '0, tmp);
      send_sample(D'(1), 1'b0, 1'b0, '0, '0, tmp);
      repeat (2) @(posedge clk);
      #1;
      write_coef(2, 7);
      send_sample(D'(1), 1'b0, 1'b0, '0, '0, tmp);
      wait_idle();
      write_coef(5, 9);
      write_coef(6, 9);
      send_sample(D'(1), 1'b0, 1'b0, '0, '0, tmp);
      wait_idle();
      tab = '{1, 3, 6, 14, 19};
      check_outputs("coef_write");

      do_reset();
      for (int i = 0; i < SZN; i++) write_coef(i, 15);
      for (int i = 0; i < SZN; i++) send_sample(D'(15), 1'b0, 1'b0, '0, '0, tmp);
      wait_idle();
      tab = '{225, 450, 163, 388, 101};
      check_outputs("max_wrap");

      // Reset asserted in the middle of RUN: back to IDLE, nothing emitted afterwards.
      do_reset();
      for (int i = 0; i < SZN; i++) write_coef(i, i + 1);
      send_sample(D'(9), 1'b0, 1'b0, '0, '0, tmp);
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush_model();
      ov_before = ov_count;
      @(negedge clk);
      check("rst_mid_smp_ready", 32'(smp_ready), 1);
      check("rst_mid_mac_en", 32'(mac_en), 0);
      check("rst_mid_ai", 32'(ai), 0);
      check("rst_mid_xni", 32'(xni), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("rst_mid_no_out_valid", ov_count - ov_before, 0);
      check("rst_mid_out_data", 32'(out_data), 0);
      got_q.delete();

      // Random samples, some with a coefficient write on the accepting edge.
      for (int n = 0; n < 25; n++) begin
         g  = $urandom_range(0, 2);
         we = ($urandom_range(0, 9) < 4);
         repeat (g) @(posedge clk);
         #1;
         send_sample(D'($urandom_range(0, 15)), 1'b0, we, KW'($urandom_range(0, 7)),
                     D'($urandom_range(0, 15)), tmp);
         wait_idle();
      end
      check("final_pairs_consumed", pair_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
